// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the key debounce front end.
//   DEB_CNT_MAX_10MS : stable cycles for a 10 ms window at 100 MHz
//   DEB_SYNC_STAGES  : default synchroniser depth
//   cnt_width()      : width of a counter that must hold 0..cnt_max
package key_debounce_pkg;

  localparam int unsigned DEB_CNT_MAX_10MS = 1000000;
  localparam int unsigned DEB_SYNC_STAGES  = 2;

  // Counter width able to represent cnt_max (so always >= 1 bit).
  function automatic int unsigned cnt_width(input int unsigned cnt_max);
    return $clog2(cnt_max + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debounce channel: synchroniser, stability counter, stable
// level flop and press/release edge strobes.
// Optional feature macro: KEY_DEBOUNCE_RELEASE_PULSE_EN (adds release_pulse).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   raw               : asynchronous raw key level
//   key_n             : debounced level, active-low (registered)
//   press_pulse       : one-cycle strobe when key_n falls (registered)
//   release_pulse     : one-cycle strobe when key_n rises (macro only)
//   stable_nxt_c      : next-cycle stable level (pressed = 1), combinational
module debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int unsigned CNT_MAX       = DEB_CNT_MAX_10MS,
  parameter int unsigned SYNC_STAGES   = DEB_SYNC_STAGES,
  parameter int unsigned IN_ACTIVE_LOW = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic key_n,
  output logic press_pulse,
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
  output logic release_pulse,
`endif
  output logic stable_nxt_c
);

  localparam int unsigned    CW   = cnt_width(CNT_MAX);
  localparam logic [CW-1:0]  LAST = CW'(CNT_MAX - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   pressed_in;
  logic                   synced;
  logic                   stable;
  logic                   accept;

  // Normalise polarity so pressed = 1 everywhere downstream.
  assign pressed_in = (IN_ACTIVE_LOW != 0) ? ~raw : raw;
  assign synced     = sync[SYNC_STAGES-1];
  // The stable level is held directly as key_n so the output is a pure flop.
  assign stable     = ~key_n;

  // Synchroniser chain; resets to the released level.
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], pressed_in};
  end

  // Stability counter: any agreeing cycle restarts the window.
  always_comb begin
    cnt_nxt      = '0;
    stable_nxt_c = stable;
    accept       = 1'b0;
    if (synced != stable) begin
      if (cnt == LAST) begin
        stable_nxt_c = synced;
        accept       = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // State and strobes; strobes coincide with the key_n change.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      key_n       <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      key_n       <= ~stable_nxt_c;
      press_pulse <= accept & synced;
    end
  end

`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
  always_ff @(posedge clk) begin
    if (rst) release_pulse <= 1'b0;
    else     release_pulse <= accept & ~synced;
  end
`endif

endmodule

// File: rtl/key_debounce_8.sv
// Input conditioning for the 8-to-3 priority encoder: WIDTH independent
// debounce channels producing active-low requests, press strobes and an
// any-key flag aligned with key_n.
// Optional feature macro: KEY_DEBOUNCE_RELEASE_PULSE_EN (adds release_pulse).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   key_raw       : asynchronous raw key levels
//   key_n         : debounced keys, active-low, bit i -> encoder Ii
//   press_pulse   : per-key one-cycle press strobe
//   release_pulse : per-key one-cycle release strobe (macro only)
//   any_key       : high while any key_n bit is 0
module key_debounce_8
  import key_debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned CNT_MAX       = DEB_CNT_MAX_10MS,
  parameter int unsigned SYNC_STAGES   = DEB_SYNC_STAGES,
  parameter int unsigned IN_ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_n,
  output logic [WIDTH-1:0] press_pulse,
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
  output logic [WIDTH-1:0] release_pulse,
`endif
  output logic             any_key
);

  logic [WIDTH-1:0] stable_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .CNT_MAX       (CNT_MAX),
      .SYNC_STAGES   (SYNC_STAGES),
      .IN_ACTIVE_LOW (IN_ACTIVE_LOW)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .raw           (key_raw[i]),
      .key_n         (key_n[i]),
      .press_pulse   (press_pulse[i]),
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
      .release_pulse (release_pulse[i]),
`endif
      .stable_nxt_c  (stable_nxt[i])
    );
  end

  // Built from next-state levels so it updates on the same edge as key_n.
  always_ff @(posedge clk) begin
    if (rst) any_key <= 1'b0;
    else     any_key <= |stable_nxt;
  end

endmodule

// File: tb/tb_key_debounce_8.sv
// Self-checking bench for key_debounce_8 with CNT_MAX = 4, SYNC_STAGES = 2.
module tb_key_debounce_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_raw;
  logic [7:0] key_n;
  logic [7:0] press_pulse;
  logic       any_key;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
  logic [7:0] release_pulse;
`endif

  key_debounce_8 #(
    .WIDTH         (8),
    .CNT_MAX       (4),
    .SYNC_STAGES   (2),
    .IN_ACTIVE_LOW (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_raw       (key_raw),
    .key_n         (key_n),
    .press_pulse   (press_pulse),
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
    .release_pulse (release_pulse),
`endif
    .any_key       (any_key)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] raw;
    logic [7:0] kn;
    logic [7:0] pp;
    logic [7:0] rp;
    logic       ak;
  } vec_t;

  vec_t vecs[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic add(input logic r, input logic [7:0] raw, input int n,
                     input logic [7:0] kn, input logic [7:0] pp,
                     input logic [7:0] rp, input logic ak);
    for (int i = 0; i < n; i++) vecs.push_back('{r, raw, kn, pp, rp, ak});
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Global watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int edge_at;
    rst     = 1'b1;
    key_raw = 8'h00;

    // Reset held with all keys raw-high; release then all keys accepted.
    add(1, 8'hFF, 3, 8'hFF, 8'h00, 8'h00, 0);
    add(0, 8'hFF, 5, 8'hFF, 8'h00, 8'h00, 0);
    add(0, 8'hFF, 1, 8'h00, 8'hFF, 8'h00, 1);
    add(0, 8'hFF, 1, 8'h00, 8'h00, 8'h00, 1);
    add(1, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 0);
    // Clean press on bit 5.
    add(0, 8'h20, 5, 8'hFF, 8'h00, 8'h00, 0);
    add(0, 8'h20, 1, 8'hDF, 8'h20, 8'h00, 1);
    add(0, 8'h20, 1, 8'hDF, 8'h00, 8'h00, 1);
    // Bounce on bit 2: high 3, low 1, then held high.
    add(0, 8'h24, 3, 8'hDF, 8'h00, 8'h00, 1);
    add(0, 8'h20, 1, 8'hDF, 8'h00, 8'h00, 1);
    add(0, 8'h24, 5, 8'hDF, 8'h00, 8'h00, 1);
    add(0, 8'h24, 1, 8'hDB, 8'h04, 8'h00, 1);
    add(0, 8'h24, 1, 8'hDB, 8'h00, 8'h00, 1);
    add(1, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 0);
    // Simultaneous press on bits 7 and 0.
    add(0, 8'h81, 5, 8'hFF, 8'h00, 8'h00, 0);
    add(0, 8'h81, 1, 8'h7E, 8'h81, 8'h00, 1);
    add(0, 8'h81, 1, 8'h7E, 8'h00, 8'h00, 1);
    // 3-cycle low glitch on bit 0 is rejected.
    add(0, 8'h80, 3, 8'h7E, 8'h00, 8'h00, 1);
    add(0, 8'h81, 6, 8'h7E, 8'h00, 8'h00, 1);
    // True release of bit 0, then bit 7.
    add(0, 8'h80, 5, 8'h7E, 8'h00, 8'h00, 1);
    add(0, 8'h80, 1, 8'h7F, 8'h00, 8'h01, 1);
    add(0, 8'h80, 1, 8'h7F, 8'h00, 8'h00, 1);
    add(0, 8'h00, 5, 8'h7F, 8'h00, 8'h00, 1);
    add(0, 8'h00, 1, 8'hFF, 8'h00, 8'h80, 0);
    add(0, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 0);
    // Press bit 0, reset mid-press, re-acquire with a fresh pulse.
    add(0, 8'h01, 5, 8'hFF, 8'h00, 8'h00, 0);
    add(0, 8'h01, 1, 8'hFE, 8'h01, 8'h00, 1);
    add(0, 8'h01, 1, 8'hFE, 8'h00, 8'h00, 1);
    add(1, 8'h01, 1, 8'hFF, 8'h00, 8'h00, 0);
    add(0, 8'h01, 5, 8'hFF, 8'h00, 8'h00, 0);
    add(0, 8'h01, 1, 8'hFE, 8'h01, 8'h00, 1);
    add(0, 8'h01, 1, 8'hFE, 8'h00, 8'h00, 1);

    foreach (vecs[i]) begin
      rst     = vecs[i].rst;
      key_raw = vecs[i].raw;
      tick();
      vectors++;
      chk("key_n", i, key_n, vecs[i].kn);
      chk("press_pulse", i, press_pulse, vecs[i].pp);
      chk("any_key", i, {7'd0, any_key}, {7'd0, vecs[i].ak});
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
      chk("release_pulse", i, release_pulse, vecs[i].rp);
`endif
    end

    // Continuous toggling on bit 3 never settles long enough.
    rst     = 1'b1;
    key_raw = 8'h00;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      key_raw = (j % 2 == 0) ? 8'h08 : 8'h00;
      tick();
      vectors++;
      chk("toggle_key_n", j, key_n, 8'hFF);
      chk("toggle_press", j, press_pulse, 8'h00);
    end

    // Hold bit 3: press strobe must arrive exactly 6 edges later.
    key_raw = 8'h08;
    found   = 0;
    edge_at = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      tick();
      if (press_pulse != 8'h00) begin
        found   = 1;
        edge_at = k;
      end
    end
    vectors++;
    if (found == 0) begin
      miscompares++;
      $display("FAIL hold_wait: no press_pulse within 20 edges, expected one at edge 6");
    end else begin
      chk("hold_latency", 0, 8'(edge_at), 8'd6);
      chk("hold_press", 0, press_pulse, 8'h08);
      chk("hold_key_n", 0, key_n, 8'hF7);
      chk("hold_any", 0, {7'd0, any_key}, 8'h01);
    end
    tick();
    vectors++;
    chk("hold_press_end", 0, press_pulse, 8'h00);
    chk("hold_key_n_end", 0, key_n, 8'hF7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_debounce_8.md
Name: key_debounce_8

Overview:
- Upstream input-conditioning stage for the 8-to-3 priority encoder on Basys3.
- Takes WIDTH raw, bouncy, asynchronous push-button/switch lines and synchronises and debounces each one.
- Presents the clean result as active-low request lines that drive the encoder's I7..I0 inputs directly.
- Also produces per-key one-cycle press strobes and an any-key flag for downstream capture logic.

Parameters:
- WIDTH, 8: number of key channels; bit i drives encoder input Ii.
- CNT_MAX, 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); must be >= 1.
- SYNC_STAGES, 2: flip-flops in each input synchroniser; must be >= 2.
- IN_ACTIVE_LOW, 0: 0 = raw input high means pressed (Basys3 buttons); 1 = raw low means pressed.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_raw  input  WIDTH  asynchronous raw key levels.
- key_n  output  WIDTH  debounced keys, active-low (0 = pressed); feeds encoder I[WIDTH-1:0].
- press_pulse  output  WIDTH  bit i high for exactly one cycle when key_n[i] goes 1->0.
- any_key  output  1  high while any key_n bit is 0.

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Reset values: synchroniser flops = released level; key_n = all ones; press_pulse = 0; any_key = 0; all counters = 0.
- Reset takes effect at the first clk edge with rst = 1.
- Normalisation: raw is converted to pressed = 1 (inverted when IN_ACTIVE_LOW = 1) before entering a SYNC_STAGES-deep flop chain per bit.
- Per channel, the state is a stable level s (pressed = 1) and a counter c of width $clog2(CNT_MAX+1).
- Each cycle with synced value equal to s: c <= 0.
- Each cycle with synced value not equal to s and c < CNT_MAX-1: c <= c+1.
- Each cycle with synced value not equal to s and c == CNT_MAX-1: s <= synced value, c <= 0.
- key_n[i] = ~s[i], registered with no extra combinational path from key_raw.
- Latency: if a raw level is held, key_n changes exactly SYNC_STAGES + CNT_MAX rising edges after the first edge that samples the new raw level.
- Glitch rejection: any synced mismatch lasting fewer than CNT_MAX cycles clears c and leaves key_n unchanged. Bouncing restarts the window from zero.
- Press and release are debounced symmetrically with the same window.
- press_pulse[i] is a registered output, asserted in the same cycle key_n[i] first reads 0, and deasserted the next cycle. A release never pulses press_pulse.
- Channels are fully independent. Simultaneous presses on several keys give simultaneous press_pulse bits; priority resolution is left to the encoder.
- any_key is registered as the OR of s, so it is aligned with key_n.
- Reset mid-press: outputs return to released at the next edge. A key still held when rst falls needs a full SYNC_STAGES + CNT_MAX window before key_n goes low again, then produces a fresh press_pulse.
- Counter saturation: c never exceeds CNT_MAX-1. There is no wrap-around.

Optional Feature:
- Macro: KEY_DEBOUNCE_RELEASE_PULSE_EN.
- Defined: extra output release_pulse[WIDTH] (reset 0). Bit i is high for exactly one cycle when key_n[i] goes 0->1, with the same timing as press_pulse.
- Undefined: the port is absent and no edge logic for releases is generated. All other behaviour is identical.

Decomposition:
- Package key_debounce_pkg holds:
  - the default constants DEB_CNT_MAX_10MS = 1000000 and DEB_SYNC_STAGES = 2;
  - the function computing counter width from CNT_MAX.
- One sub-module, debounce_channel, handles a single bit: synchroniser, counter, stable flop and edge detect.
- key_debounce_8 instantiates WIDTH copies of debounce_channel in a generate loop and forms any_key.

Test Plan (CNT_MAX = 4, SYNC_STAGES = 2, IN_ACTIVE_LOW = 0):
- Reset: hold rst for 3 cycles with key_raw = 8'hFF -> key_n = 8'hFF, press_pulse = 0, any_key = 0 throughout. After release, key_n goes 8'h00 6 edges later.
- Clean press: raw bit 5 goes 0->1 and is held -> key_n = 8'hDF exactly 6 edges after the first sampling edge; press_pulse = 8'h20 for 1 cycle; any_key = 1.
- Bounce: raw bit 2 toggles high 3 cycles / low 1 cycle / high 2 cycles, then holds high -> no change until 4 consecutive synced-high cycles. Then key_n[2] = 0 with a single press_pulse[2].
- Simultaneous: raw bits 7 and 0 rise on the same edge -> key_n = 8'h7E, press_pulse = 8'h81 in one cycle. Encoder output then shows code 7 with GS = 0.
- Release and glitch: a 3-cycle low glitch on a held key leaves key_n unchanged. A true release restores key_n[i] = 1 after 6 edges, with no press_pulse and a release_pulse only when KEY_DEBOUNCE_RELEASE_PULSE_EN is defined.
- Reset mid-press: assert rst while key_n = 8'hFE with raw still held -> key_n = 8'hFF next edge. After rst deasserts, key_n = 8'hFE again after 6 edges, with a new press_pulse.
